// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter feeding one UART TX FIFO, with a stall watchdog.
// Optional macro UART_TX_ARB_TAG_EN: prefix every packet with a header beat carrying the owner index.
module uart_tx_arb #(
    parameter int p_req_cnt     = 4,
    parameter int p_bit_cnt     = 8,
    parameter int p_timeout_cnt = 1000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [p_req_cnt-1:0]             i_req_valid,
    input  logic [p_req_cnt*p_bit_cnt-1:0]   i_req_data,
    input  logic [p_req_cnt-1:0]             i_req_last,
    output logic [p_req_cnt-1:0]             o_req_ready,
    output logic [p_bit_cnt-1:0]             o_fifo_wr_data,
    output logic                             o_fifo_wr_en,
    input  logic                             i_fifo_full,
    output logic [$clog2(p_req_cnt)-1:0]     o_grant,
    output logic                             o_busy,
    output logic                             o_timeout
);

    localparam int GW = $clog2(p_req_cnt);
    localparam int WW = $clog2(p_timeout_cnt);

    typedef enum logic [1:0] {
        s_idle = 2'd0,
`ifdef UART_TX_ARB_TAG_EN
        s_tag  = 2'd1,
`endif
        s_pass = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic                 pickFound;
    logic [GW-1:0]        pickIdx;
    logic [GW-1:0]        candidate;
    logic [p_bit_cnt-1:0] dataSel;
    logic                 validG;
    logic                 lastG;
    logic                 xfer;
    logic                 wdInc;
    logic                 wdExpire;
`ifdef UART_TX_ARB_TAG_EN
    logic [p_bit_cnt-1:0] header;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= s_idle;
            grant_q <= '0;
            last_q  <= GW'(p_req_cnt - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        candidate = '0;
        for (int i = 1; i <= p_req_cnt; i++) begin
            candidate = GW'((int'(last_q) + i) % p_req_cnt);
            if (!pickFound && i_req_valid[candidate]) begin
                pickFound = 1'b1;
                pickIdx   = candidate;
            end
        end
    end

    always_comb begin
        dataSel = '0;
        for (int k = 0; k < p_req_cnt; k++) begin
            if (grant_q == GW'(k)) begin
                dataSel = i_req_data[k*p_bit_cnt +: p_bit_cnt];
            end
        end
    end

    assign validG   = i_req_valid[grant_q];
    assign lastG    = i_req_last[grant_q];
    assign xfer     = (state_q == s_pass) && validG && !i_fifo_full;
    // Only stalls caused by the owner count; a full FIFO is not its fault.
    assign wdInc    = (state_q == s_pass) && !validG && !i_fifo_full;
    assign wdExpire = wdInc && (wd_q == WW'(p_timeout_cnt - 1));

`ifdef UART_TX_ARB_TAG_EN
    always_comb begin
        header                = '0;
        header[GW-1:0]        = grant_q;
        header[p_bit_cnt-1]   = 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            s_idle: begin
                if (pickFound) begin
                    grant_d = pickIdx;
                    wd_d    = '0;
`ifdef UART_TX_ARB_TAG_EN
                    state_d = s_tag;
`else
                    state_d = s_pass;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            s_tag: begin
                if (!i_fifo_full) begin
                    state_d = s_pass;
                    wd_d    = '0;
                end
            end
`endif
            s_pass: begin
                if (xfer) begin
                    wd_d = '0;
                    if (lastG) begin
                        last_d  = grant_q;
                        state_d = s_idle;
                    end
                end else if (wdExpire) begin
                    wd_d    = '0;
                    last_d  = grant_q;
                    state_d = s_idle;
                end else if (wdInc) begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = s_idle;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, whatever the state register holds.
    always_comb begin
        o_req_ready    = '0;
        o_fifo_wr_en   = 1'b0;
        o_fifo_wr_data = '0;
        o_timeout      = 1'b0;
        if (!i_rst) begin
            if (state_q == s_pass) begin
                for (int k = 0; k < p_req_cnt; k++) begin
                    if (grant_q == GW'(k)) begin
                        o_req_ready[k] = !i_fifo_full;
                    end
                end
            end
            if (xfer) begin
                o_fifo_wr_en   = 1'b1;
                o_fifo_wr_data = dataSel;
            end
`ifdef UART_TX_ARB_TAG_EN
            if ((state_q == s_tag) && !i_fifo_full) begin
                o_fifo_wr_en   = 1'b1;
                o_fifo_wr_data = header;
            end
`endif
            o_timeout = wdExpire;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != s_idle) && !i_rst;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (4 requesters, 8-bit beats, watchdog of 8).
// Also follows the header beat when built with UART_TX_ARB_TAG_EN.
module tb_uart_tx_arb;

    logic        clock;
    logic        rst;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic [7:0]  fifoWrData;
    logic        fifoWrEn;
    logic        fifoFull;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    uart_tx_arb #(
        .p_req_cnt     (4),
        .p_bit_cnt     (8),
        .p_timeout_cnt (8)
    ) dut (
        .i_clk          (clock),
        .i_rst          (rst),
        .i_req_valid    (reqValid),
        .i_req_data     (reqData),
        .i_req_last     (reqLast),
        .o_req_ready    (reqReady),
        .o_fifo_wr_data (fifoWrData),
        .o_fifo_wr_en   (fifoWrEn),
        .i_fifo_full    (fifoFull),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_timeout      (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPort(input string tag, input logic wrEn, input logic [7:0] data,
                             input logic [3:0] ready, input logic isBusy, input logic isTimeout);
        checkOutput({tag, "_wr_en"},   32'(fifoWrEn),   32'(wrEn));
        checkOutput({tag, "_wr_data"}, 32'(fifoWrData), 32'(data));
        checkOutput({tag, "_ready"},   32'(reqReady),   32'(ready));
        checkOutput({tag, "_busy"},    32'(busy),       32'(isBusy));
        checkOutput({tag, "_timeout"}, 32'(timeout),    32'(isTimeout));
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                                 input logic [31:0] data, input logic full);
        reqValid = valid;
        reqLast  = last;
        reqData  = data;
        fifoFull = full;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset is applied with every requester shouting, to show outputs stay quiet.
    task automatic doReset(input string tag);
        rst = 1'b1;
        applyStimulus(4'hF, 4'hF, 32'hFFFF_FFFF, 1'b0);
        checkPort({tag, "_rst"}, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(4'h0, 4'h0, 32'h0, 1'b0);
        checkOutput({tag, "_rst_grant"}, 32'(grant), 32'd0);
        checkPort({tag, "_post_rst"}, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic tagBeat(input string tag, input logic [1:0] g);
`ifdef UART_TX_ARB_TAG_EN
        checkPort({tag, "_hdr"}, 1'b1, {1'b1, 5'b00000, g}, 4'b0000, 1'b1, 1'b0);
        tick();
`endif
    endtask

    initial begin
        rst      = 1'b0;
        reqValid = '0;
        reqLast  = '0;
        reqData  = '0;
        fifoFull = 1'b0;
        tick();

        // Single requester, three beats.
        doReset("t1");
        applyStimulus(4'b0100, 4'b0000, 32'h0011_0000, 1'b0);
        checkPort("t1_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        tagBeat("t1", 2'd2);
        checkPort("t1_b1", 1'b1, 8'h11, 4'b0100, 1'b1, 1'b0);
        checkOutput("t1_grant", 32'(grant), 32'd2);
        tick();
        applyStimulus(4'b0100, 4'b0000, 32'h0022_0000, 1'b0);
        checkPort("t1_b2", 1'b1, 8'h22, 4'b0100, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0100, 4'b0100, 32'h0033_0000, 1'b0);
        checkPort("t1_b3", 1'b1, 8'h33, 4'b0100, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        checkPort("t1_done", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();

        // Round robin: all four hold single-beat packets.
        doReset("t2");
        applyStimulus(4'b1111, 4'b1111, 32'hA3A2_A1A0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            checkPort($sformatf("t2_idle%0d", n), 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
            tick();
            tagBeat($sformatf("t2_p%0d", n), 2'(n % 4));
            checkPort($sformatf("t2_p%0d", n), 1'b1, 8'hA0 + 8'(n % 4), 4'(1 << (n % 4)), 1'b1, 1'b0);
            checkOutput($sformatf("t2_grant%0d", n), 32'(grant), 32'(n % 4));
            tick();
        end
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        tick();

        // Packet lock: requester 0 shows up during requester 1's packet.
        doReset("t3");
        applyStimulus(4'b0010, 4'b0000, 32'h0000_B100, 1'b0);
        checkPort("t3_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        tagBeat("t3", 2'd1);
        checkPort("t3_b1", 1'b1, 8'hB1, 4'b0010, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0011, 4'b0001, 32'h0000_B2C0, 1'b0);
        checkPort("t3_b2", 1'b1, 8'hB2, 4'b0010, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0011, 4'b0001, 32'h0000_B3C0, 1'b0);
        checkPort("t3_b3", 1'b1, 8'hB3, 4'b0010, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0011, 4'b0011, 32'h0000_B4C0, 1'b0);
        checkPort("t3_b4", 1'b1, 8'hB4, 4'b0010, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0001, 4'b0001, 32'h0000_00C0, 1'b0);
        checkPort("t3_gap", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        tagBeat("t3_r0", 2'd0);
        checkPort("t3_r0", 1'b1, 8'hC0, 4'b0001, 1'b1, 1'b0);
        checkOutput("t3_grant0", 32'(grant), 32'd0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        tick();

        // FIFO backpressure for five cycles mid-packet.
        doReset("t4");
        applyStimulus(4'b1000, 4'b0000, 32'hD100_0000, 1'b0);
        checkPort("t4_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        tagBeat("t4", 2'd3);
        checkPort("t4_b1", 1'b1, 8'hD1, 4'b1000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b1000, 4'b0000, 32'hD200_0000, 1'b1);
        for (int n = 0; n < 5; n++) begin
            checkPort($sformatf("t4_full%0d", n), 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(4'b1000, 4'b0000, 32'hD200_0000, 1'b0);
        checkPort("t4_b2", 1'b1, 8'hD2, 4'b1000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b1000, 4'b1000, 32'hD300_0000, 1'b0);
        checkPort("t4_b3", 1'b1, 8'hD3, 4'b1000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        checkPort("t4_done", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();

        // Watchdog: owner 0 stalls after one beat; one full cycle does not count.
        doReset("t5");
        applyStimulus(4'b0001, 4'b0000, 32'h0000_00E1, 1'b0);
        checkPort("t5_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        tagBeat("t5", 2'd0);
        checkPort("t5_b1", 1'b1, 8'hE1, 4'b0001, 1'b1, 1'b0);
        tick();
        for (int n = 1; n <= 8; n++) begin
            if (n == 4) begin
                applyStimulus(4'b0010, 4'b0000, 32'h0000_F100, 1'b1);
                checkPort("t5_full", 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
                tick();
            end
            applyStimulus(4'b0010, 4'b0000, 32'h0000_F100, 1'b0);
            checkPort($sformatf("t5_stall%0d", n), 1'b0, 8'h00, 4'b0001, 1'b1, 1'(n == 8));
            tick();
        end
        checkPort("t5_rearb", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        tagBeat("t5_r1", 2'd1);
        checkPort("t5_r1b1", 1'b1, 8'hF1, 4'b0010, 1'b1, 1'b0);
        checkOutput("t5_grant1", 32'(grant), 32'd1);
        tick();
        applyStimulus(4'b0010, 4'b0000, 32'h0000_F200, 1'b0);
        checkPort("t5_r1b2", 1'b1, 8'hF2, 4'b0010, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkPort("t5_in_rst", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        checkPort("t5_after_rst", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        checkOutput("t5_rst_grant", 32'(grant), 32'd0);
        tick();

        // Single-byte packet from requester 3 (header first when tagging is built in).
        doReset("t6");
        applyStimulus(4'b1000, 4'b1000, 32'h5A00_0000, 1'b0);
        checkPort("t6_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();
`ifdef UART_TX_ARB_TAG_EN
        checkPort("t6_hdr", 1'b1, 8'h83, 4'b0000, 1'b1, 1'b0);
        tick();
`endif
        checkPort("t6_b1", 1'b1, 8'h5A, 4'b1000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        checkPort("t6_done", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares one UART transmit path among `p_req_cnt` requesters. It sits in front of the TX FIFO feeding the UART transmitter and writes into it with the same FIFO write interface the UART receiver uses. A grant is held for a whole packet, from grant to the beat flagged last, so bytes from different requesters never interleave. A watchdog releases a grant whose owner stalls mid-packet.

## Interface
- `p_req_cnt`, 4: number of requesters, 2..16.
- `p_bit_cnt`, 4'd8: data width per beat. Must exceed `$clog2(p_req_cnt)`.
- `p_timeout_cnt`, 1000: idle-valid cycles tolerated mid-packet before the grant is revoked, ≥2.

Ports:
- `i_clk`, in, 1: clock. All logic is on the rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_req_valid`, in, `p_req_cnt`: per-requester beat valid.
- `i_req_data`, in, `p_req_cnt*p_bit_cnt`: beats packed; requester k occupies `[k*p_bit_cnt +: p_bit_cnt]`.
- `i_req_last`, in, `p_req_cnt`: marks the final beat of a packet.
- `o_req_ready`, out, `p_req_cnt`: per-requester ready.
- `o_fifo_wr_data`, out, `p_bit_cnt`: byte written to the TX FIFO.
- `o_fifo_wr_en`, out, 1: TX FIFO write strobe.
- `i_fifo_full`, in, 1: TX FIFO full.
- `o_grant`, out, `$clog2(p_req_cnt)`: index of the current owner.
- `o_busy`, out, 1: high while not in `s_idle`.
- `o_timeout`, out, 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
States: `s_idle`, `s_tag` (only when the macro is defined), `s_pass`.

**Arbitration (`s_idle`)**
- Requester k is eligible when `i_req_valid[k]` is high.
- Priority is searched from `r_last+1`, wrapping modulo `p_req_cnt`.
- The first eligible requester is latched into `o_grant`.
- Next state is `s_tag` if the macro is defined, otherwise `s_pass`.
- No eligible requester: stay in `s_idle`.
- `o_req_ready` is all zero in this state.

**Transfer (`s_pass`)**
- `o_req_ready[g] = ~i_fifo_full` for g = `o_grant`; all other ready bits are 0.
- A transfer occurs when `i_req_valid[g] & o_req_ready[g]`.
- `o_fifo_wr_en` equals the transfer condition, combinationally.
- `o_fifo_wr_data` is requester g's data slice.
- A transfer with `i_req_last[g]` high sets `r_last <= g` and returns to `s_idle`.

**Watchdog**
- `r_wd` clears on entry to `s_pass` and on every transfer.
- `r_wd` increments on cycles where `~i_req_valid[g] & ~i_fifo_full`.
- FIFO-full cycles do not count, since that stall is not the requester's fault.
- When `r_wd == p_timeout_cnt - 1` and it would increment again:
  - pulse `o_timeout`,
  - set `r_last <= g`,
  - go to `s_idle`.
- No partial-packet marker is written to the FIFO.

**Reset**
- `i_rst` wins over all other events.
- State → `s_idle`, `o_grant` → 0, `r_last` → `p_req_cnt-1` (requester 0 gets first priority), `r_wd` → 0.
- Reset in the middle of a packet drops the remainder silently. Requesters must also be reset.
- Output values during reset:
  - `o_req_ready` = 0
  - `o_fifo_wr_en` = 0
  - `o_busy` = 0
  - `o_timeout` = 0
  - `o_fifo_wr_data` = 0 (forced to 0 whenever not writing)

## Timing
- Request to first data write: 2 cycles without the macro (arbitrate, then pass); 3 cycles with it (arbitrate, tag, pass).
- Within `s_pass` the data path is zero latency: ready, write enable and data are combinational from inputs and state.
- Throughput within a packet is one beat per cycle while the FIFO is not full.
- Re-arbitration bubble: one idle cycle between packets.
- A single-beat packet (valid and last on the first beat) occupies `s_pass` for one cycle.
- The `i_fifo_full` handshake is combinational, so a full FIFO is never written.
- Requesters must not deassert valid while ready is low. This is not checked.

## Configuration
- `UART_TX_ARB_TAG_EN` defined: each packet is preceded by a header beat written in `s_tag`.
  - Header value = `o_grant` zero-extended to `p_bit_cnt`, with bit `p_bit_cnt-1` forced to 1.
  - The header is written when `~i_fifo_full`; if the FIFO is full, the block waits in `s_tag`.
  - `o_req_ready` is 0 during `s_tag`.
  - The watchdog does not run in `s_tag`.
- `UART_TX_ARB_TAG_EN` not defined: `s_tag` does not exist and the output contains payload bytes only.

## Test plan
1. **Single requester.** Requester 2 sends 3 beats 0x11, 0x22, 0x33 with last on 0x33. FIFO writes exactly 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after valid. `o_grant` = 2. `o_busy` falls the cycle after the last write.
2. **Round robin under contention.** All 4 requesters hold valid with single-beat packets, starting after reset. Grant order is 0, 1, 2, 3, 0, with one idle cycle between packets.
3. **Packet lock.** Requester 1 sends a 4-beat packet while requester 0 asserts valid at beat 2. No byte from requester 0 appears until after requester 1's last beat.
4. **FIFO backpressure.** `i_fifo_full` held high for 5 cycles mid-packet. No writes occur, `o_req_ready` stays 0, `o_timeout` stays 0, and the remaining beats resume in order.
5. **Watchdog.** `p_timeout_cnt` = 8; the owner drops valid after beat 1. `o_timeout` pulses exactly 8 non-full cycles later, the next requester is granted, and a reset mid-packet returns `o_busy` to 0 on the next cycle.
6. **Tag header.** With `UART_TX_ARB_TAG_EN` and p_bit_cnt=8, requester 3 sends one byte 0x5A. FIFO receives 0x83 then 0x5A.
